// File: rtl/vga_frame_checker_if.sv
// Expected-pixel stream handshake between a reference source and vga_frame_checker.
// The master supplies packed {R,G,B} pixels; the checker pops one per compared pixel.
interface vga_frame_checker_if #(
  parameter int EXP_W = 8
);
  logic               Exp_valid;
  logic [3*EXP_W-1:0] Exp_data;
  logic               Exp_ready;

  modport master (output Exp_valid, output Exp_data, input  Exp_ready);
  modport slave  (input  Exp_valid, input  Exp_data, output Exp_ready);
endinterface

// File: rtl/vga_frame_checker.sv
// In-circuit VGA frame checker: compares windowed pixels against an expected stream.
// Optional feature macro: FRAME_CRC_EN adds a CRC-16-CCITT over checked pixels on Frame_crc.
module vga_frame_checker #(
  parameter int PIX_W          = 10,
  parameter int COLOR_W        = 10,
  parameter int EXP_W          = 8,
  parameter int VIEW_LEFT      = 160,
  parameter int VIEW_RIGHT     = 480,
  parameter int VIEW_TOP       = 120,
  parameter int VIEW_BOTTOM    = 360,
  parameter int MAX_MISMATCHES = 10,
  parameter int CNT_W          = 16
) (
  input  logic               Clock_50,
  input  logic               Resetn,
  input  logic               Start,
  input  logic               VGA_Vsync,
  input  logic               Pixel_en,
  input  logic [PIX_W-1:0]   Pixel_X,
  input  logic [PIX_W-1:0]   Pixel_Y,
  input  logic [COLOR_W-1:0] VGA_red,
  input  logic [COLOR_W-1:0] VGA_green,
  input  logic [COLOR_W-1:0] VGA_blue,
  vga_frame_checker_if.slave exp_if,
  output logic               Busy,
  output logic               Done,
  output logic               Abort,
  output logic               Underrun,
  output logic [CNT_W-1:0]   Mismatch_count,
  output logic               First_valid,
  output logic [PIX_W-1:0]   First_X,
  output logic [PIX_W-1:0]   First_Y
`ifdef FRAME_CRC_EN
  ,
  output logic [15:0]        Frame_crc
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_VS_LO, S_WAIT_VS_HI, S_CHECK, S_DONE, S_ABORT
  } state_t;

  state_t             state_q, state_d;
  logic               vsync_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               abort_q, abort_d;
  logic               underrun_q, underrun_d;
  logic               first_valid_q, first_valid_d;
  logic [PIX_W-1:0]   first_x_q, first_x_d;
  logic [PIX_W-1:0]   first_y_q, first_y_d;

  logic               in_window, checking, pop, start_clear;
  logic [COLOR_W-1:0] exp_r, exp_g, exp_b;
  logic               miss_r, miss_g, miss_b;
  logic [1:0]         miss_sum;
  logic [CNT_W+1:0]   count_sum;

`ifdef FRAME_CRC_EN
  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in,
                                             input logic [3*COLOR_W-1:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 3*COLOR_W-1; i >= 0; i--) begin
      c = (c[15] ^ data[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  // Datapath: window qualification, channel compare and the sticky status updates.
  always_comb begin
    in_window = (Pixel_X >= PIX_W'(VIEW_LEFT)) && (Pixel_X < PIX_W'(VIEW_RIGHT)) &&
                (Pixel_Y >= PIX_W'(VIEW_TOP))  && (Pixel_Y < PIX_W'(VIEW_BOTTOM));
    checking  = (state_q == S_CHECK) && Pixel_en && in_window;
    pop       = checking && exp_if.Exp_valid;
    start_clear = Start && ((state_q == S_IDLE) || (state_q == S_ABORT));

    // Expected channels are left-aligned so their MSBs line up with the VGA channel.
    exp_r = COLOR_W'(exp_if.Exp_data[3*EXP_W-1 -: EXP_W]) << (COLOR_W - EXP_W);
    exp_g = COLOR_W'(exp_if.Exp_data[2*EXP_W-1 -: EXP_W]) << (COLOR_W - EXP_W);
    exp_b = COLOR_W'(exp_if.Exp_data[EXP_W-1   -: EXP_W]) << (COLOR_W - EXP_W);
    miss_r = pop && (VGA_red   != exp_r);
    miss_g = pop && (VGA_green != exp_g);
    miss_b = pop && (VGA_blue  != exp_b);
    miss_sum  = 2'(miss_r) + 2'(miss_g) + 2'(miss_b);
    count_sum = (CNT_W+2)'(count_q) + (CNT_W+2)'(miss_sum);

    count_d       = (count_sum[CNT_W+1:CNT_W] != 2'b00) ? '1 : count_sum[CNT_W-1:0];
    underrun_d    = underrun_q || (checking && !exp_if.Exp_valid);
    first_valid_d = first_valid_q;
    first_x_d     = first_x_q;
    first_y_d     = first_y_q;
    if ((miss_sum != 2'd0) && !first_valid_q) begin
      first_valid_d = 1'b1;
      first_x_d     = Pixel_X;
      first_y_d     = Pixel_Y;
    end
`ifdef FRAME_CRC_EN
    crc_d = checking ? crc16_step(crc_q, {VGA_red, VGA_green, VGA_blue}) : crc_q;
`endif

    if (start_clear) begin
      count_d       = '0;
      underrun_d    = 1'b0;
      first_valid_d = 1'b0;
      first_x_d     = '0;
      first_y_d     = '0;
`ifdef FRAME_CRC_EN
      crc_d         = 16'hFFFF;
`endif
    end
  end

  // Frame sequencing; the abort threshold takes priority over end of frame.
  always_comb begin
    state_d = state_q;
    abort_d = abort_q && !start_clear;
    unique case (state_q)
      S_IDLE:       if (Start) state_d = S_WAIT_VS_LO;
      S_WAIT_VS_LO: if (!VGA_Vsync) state_d = S_WAIT_VS_HI;
      S_WAIT_VS_HI: if (VGA_Vsync) state_d = S_CHECK;
      S_CHECK: begin
        if (count_q > CNT_W'(MAX_MISMATCHES)) begin
          state_d = S_ABORT;
          abort_d = 1'b1;
        end else if (vsync_q && !VGA_Vsync) begin
          state_d = S_DONE;
        end
      end
      S_DONE:       state_d = S_IDLE;
      S_ABORT:      if (Start) state_d = S_WAIT_VS_LO;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q       <= S_IDLE;
      vsync_q       <= 1'b1;
      count_q       <= '0;
      abort_q       <= 1'b0;
      underrun_q    <= 1'b0;
      first_valid_q <= 1'b0;
      first_x_q     <= '0;
      first_y_q     <= '0;
`ifdef FRAME_CRC_EN
      crc_q         <= 16'hFFFF;
`endif
    end else begin
      state_q       <= state_d;
      vsync_q       <= VGA_Vsync;
      count_q       <= count_d;
      abort_q       <= abort_d;
      underrun_q    <= underrun_d;
      first_valid_q <= first_valid_d;
      first_x_q     <= first_x_d;
      first_y_q     <= first_y_d;
`ifdef FRAME_CRC_EN
      crc_q         <= crc_d;
`endif
    end
  end

  assign exp_if.Exp_ready = pop;
  assign Busy           = (state_q != S_IDLE);
  assign Done           = (state_q == S_DONE);
  assign Abort          = abort_q;
  assign Underrun       = underrun_q;
  assign Mismatch_count = count_q;
  assign First_valid    = first_valid_q;
  assign First_X        = first_x_q;
  assign First_Y        = first_y_q;
`ifdef FRAME_CRC_EN
  assign Frame_crc      = crc_q;
`endif

endmodule
